// File: rtl/t9990_blit_rdpix_pkg.sv
// t9990_blit_rdpix_pkg: colour/width mode codes, FSM states and address helpers
// for the tiny9990 blitter pixel-read unit.
package t9990_blit_rdpix_pkg;

  // Colour mode codes (CLRM register field)
  localparam logic [1:0] CLRM_2BPP  = 2'd0;
  localparam logic [1:0] CLRM_4BPP  = 2'd1;
  localparam logic [1:0] CLRM_8BPP  = 2'd2;
  localparam logic [1:0] CLRM_16BPP = 2'd3;

  // Image width codes (XIMM register field)
  localparam logic [1:0] XIMM_256  = 2'd0;
  localparam logic [1:0] XIMM_512  = 2'd1;
  localparam logic [1:0] XIMM_1024 = 2'd2;
  localparam logic [1:0] XIMM_2048 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_MREQ,
    ST_MWAIT,
    ST_RESP
  } state_e;

  // log2(pixels per 32-bit word) for a colour mode
  function automatic logic [2:0] shift_amt(input logic [1:0] clrm);
    logic [2:0] s;
    case (clrm)
      CLRM_2BPP: s = 3'd4;
      CLRM_4BPP: s = 3'd3;
      CLRM_8BPP: s = 3'd2;
      default:   s = 3'd1;
    endcase
    return s;
  endfunction

  // VRAM byte address of the word holding pixel (x, y)
  function automatic logic [18:0] pix_addr(input logic [10:0] x, input logic [11:0] y,
                                           input logic [1:0] clrm, input logic [1:0] ximm,
                                           input logic p1);
    logic [2:0]  s;
    logic [3:0]  w;
    logic [10:0] xs;
    logic [10:0] xmask;
    logic [16:0] word;
    logic [18:0] addr;
    s     = shift_amt(clrm);
    // X field width: log2(line width in pixels) minus log2(pixels per word)
    w     = 4'd8 + {2'b00, ximm} - {1'b0, s};
    xs    = x >> s;
    xmask = (11'd1 << w) - 11'd1;
    word  = ({5'd0, y} << w) | {6'd0, xs & xmask};
    if (p1) begin
      addr = {x[9], y[9:0], x[8:3], 2'b00};
    end else if ((clrm == CLRM_2BPP) && (ximm == XIMM_256)) begin
      addr = {1'b0, y, x[7:4], 2'b00};
    end else begin
      addr = {word, 2'b00};
    end
    return addr;
  endfunction

endpackage

// File: rtl/t9990_blit_rdpix_if.sv
// t9990_blit_rdpix_if: request, response and VRAM read port of the pixel-read unit.
// slave = the pixel-read unit, master = sequencer/arbiter side.
interface t9990_blit_rdpix_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [10:0] REQ_X;
  logic [11:0] REQ_Y;
  logic [1:0]  CLRM;
  logic [1:0]  XIMM;
  logic        P1;
  logic        MEM_REQ;
  logic [18:0] MEM_ADDR;
  logic        MEM_ACK;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [15:0] RSP_PIX;
  logic        INVALIDATE;

  modport slave (
    input  REQ_VALID, REQ_X, REQ_Y, CLRM, XIMM, P1,
    input  MEM_ACK, MEM_RVALID, MEM_RDATA, RSP_READY, INVALIDATE,
    output REQ_READY, MEM_REQ, MEM_ADDR, RSP_VALID, RSP_PIX
  );

  modport master (
    output REQ_VALID, REQ_X, REQ_Y, CLRM, XIMM, P1,
    output MEM_ACK, MEM_RVALID, MEM_RDATA, RSP_READY, INVALIDATE,
    input  REQ_READY, MEM_REQ, MEM_ADDR, RSP_VALID, RSP_PIX
  );
endinterface

// File: rtl/t9990_blit_rdpix_pix_sel.sv
// t9990_blit_pix_sel: extracts one pixel from a 32-bit VRAM word.
// Leftmost pixel sits in the most significant bits of each byte; P1 is 4bpp.
module t9990_blit_pix_sel
  import t9990_blit_rdpix_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  clrm,
  input  logic        p1,
  input  logic [3:0]  x,
  output logic [15:0] pix
);

  logic [7:0] byte_sel;

  // Select byte/halfword by the low X bits, then the pixel within the byte
  always_comb begin
    pix      = '0;
    byte_sel = '0;
    if (p1 || (clrm == CLRM_4BPP)) begin
      byte_sel = word[{x[2:1], 3'b000} +: 8];
      pix      = {12'd0, (x[0] ? byte_sel[3:0] : byte_sel[7:4])};
    end else begin
      case (clrm)
        CLRM_2BPP: begin
          byte_sel = word[{x[3:2], 3'b000} +: 8];
          // pixel k of the byte occupies bits [7-2k -: 2]; 7-2k == {~k, 1}
          pix      = {14'd0, byte_sel[{~x[1:0], 1'b1} -: 2]};
        end
        CLRM_8BPP: begin
          pix = {8'd0, word[{x[1:0], 3'b000} +: 8]};
        end
        default: begin
          pix = x[0] ? word[31:16] : word[15:0];
        end
      endcase
    end
  end

endmodule

// File: rtl/t9990_blit_rdpix.sv
// t9990_blit_rdpix: blitter pixel-read unit. Accepts a pixel coordinate and
// mode, fetches the containing VRAM word and returns the zero-extended pixel.
// Optional feature: define T9990_BLIT_RDCACHE_EN to build the one-word read cache.
module t9990_blit_rdpix
  import t9990_blit_rdpix_pkg::*;
(
  input logic               CLK,
  input logic               RESET_n,
  t9990_blit_rdpix_if.slave bus
);

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [1:0]  clrm_q, clrm_d;
  logic [1:0]  ximm_q, ximm_d;
  logic        p1_q, p1_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic [15:0] pix_q, pix_d;

  logic [18:0] addr_calc;
  logic        hit;
  logic        capture;
  logic [31:0] cache_word;
  logic [31:0] sel_word;
  logic [15:0] sel_pix;

  assign addr_calc = pix_addr(x_q, y_q, clrm_q, ximm_q, p1_q);

  // A read word is only taken while the FSM is waiting for it
  assign capture = ((state_q == ST_MREQ) && bus.MEM_ACK && bus.MEM_RVALID) ||
                   ((state_q == ST_MWAIT) && bus.MEM_RVALID);

`ifdef T9990_BLIT_RDCACHE_EN
  logic        cache_vld_q, cache_vld_d;
  logic [18:0] cache_tag_q, cache_tag_d;
  logic [31:0] cache_word_q, cache_word_d;

  assign hit        = cache_vld_q && (cache_tag_q == addr_calc);
  assign cache_word = cache_word_q;

  // Fill on every captured read; INVALIDATE wins over a coincident fill
  always_comb begin
    cache_vld_d  = cache_vld_q;
    cache_tag_d  = cache_tag_q;
    cache_word_d = cache_word_q;
    if (capture) begin
      cache_vld_d  = 1'b1;
      cache_tag_d  = mem_addr_q;
      cache_word_d = bus.MEM_RDATA;
    end
    if (bus.INVALIDATE) begin
      cache_vld_d = 1'b0;
    end
  end

  // Cache valid bit; only control state is reset
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cache_vld_q <= 1'b0;
    end else begin
      cache_vld_q <= cache_vld_d;
    end
  end

  // Cache tag and data, qualified by the valid bit
  always_ff @(posedge CLK) begin
    cache_tag_q  <= cache_tag_d;
    cache_word_q <= cache_word_d;
  end
`else
  logic unused_inv;

  assign hit        = 1'b0;
  assign cache_word = '0;
  assign unused_inv = bus.INVALIDATE;
`endif

  // ADDR extracts from the cached word on a hit; otherwise from the read bus
  assign sel_word = (state_q == ST_ADDR) ? cache_word : bus.MEM_RDATA;

  t9990_blit_pix_sel u_pix_sel (
    .word (sel_word),
    .clrm (clrm_q),
    .p1   (p1_q),
    .x    (x_q[3:0]),
    .pix  (sel_pix)
  );

  // Transaction FSM: next state, request latch, address and pixel registers
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    clrm_d     = clrm_q;
    ximm_d     = ximm_q;
    p1_d       = p1_q;
    mem_addr_d = mem_addr_q;
    pix_d      = pix_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.REQ_VALID) begin
          x_d     = bus.REQ_X;
          y_d     = bus.REQ_Y;
          clrm_d  = bus.CLRM;
          ximm_d  = bus.XIMM;
          p1_d    = bus.P1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        mem_addr_d = addr_calc;
        if (hit) begin
          pix_d   = sel_pix;
          state_d = ST_RESP;
        end else begin
          state_d = ST_MREQ;
        end
      end
      ST_MREQ: begin
        if (bus.MEM_ACK) begin
          if (bus.MEM_RVALID) begin
            pix_d   = sel_pix;
            state_d = ST_RESP;
          end else begin
            state_d = ST_MWAIT;
          end
        end
      end
      ST_MWAIT: begin
        if (bus.MEM_RVALID) begin
          pix_d   = sel_pix;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.RSP_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and visible outputs; reset aborts any transaction at once
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      pix_q      <= pix_d;
    end
  end

  // Request fields sampled at accept; not visible until loaded
  always_ff @(posedge CLK) begin
    x_q    <= x_d;
    y_q    <= y_d;
    clrm_q <= clrm_d;
    ximm_q <= ximm_d;
    p1_q   <= p1_d;
  end

  assign bus.REQ_READY = (state_q == ST_IDLE) && RESET_n;
  assign bus.MEM_REQ   = (state_q == ST_MREQ);
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.RSP_VALID = (state_q == ST_RESP);
  assign bus.RSP_PIX   = pix_q;

endmodule

// File: tb/tb_t9990_blit_rdpix.sv
// tb_t9990_blit_rdpix: randomized self-checking bench for the pixel-read unit,
// with a behavioural VRAM/cache reference model.
module tb_t9990_blit_rdpix;
  import t9990_blit_rdpix_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  t9990_blit_rdpix_if bus();

  t9990_blit_rdpix dut (
    .CLK     (clk),
    .RESET_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

`ifdef T9990_BLIT_RDCACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  // Reference cache and VRAM contents (byte address keyed)
  bit          m_vld = 1'b0;
  int          m_tag = 0;
  logic [31:0] m_word = '0;
  logic [31:0] vram [int];

  // Word address from line geometry: words per line times Y plus X's word
  function automatic int ref_addr(input int x, input int y, input int clrm, input int ximm,
                                  input bit p1);
    int bpp, ppw, width, word;
    if (p1) begin
      word = ((x / 512) % 2) * 65536 + (y % 1024) * 64 + (x / 8) % 64;
    end else begin
      bpp   = 2 << clrm;
      ppw   = 32 / bpp;
      width = 256 << ximm;
      word  = (y * (width / ppw) + (x % width) / ppw) % 131072;
    end
    return word * 4;
  endfunction

  // Pixel k of a word: bytes in little-endian order, leftmost pixel at byte MSBs
  function automatic logic [15:0] ref_pix(input logic [31:0] w, input int x, input int clrm,
                                          input bit p1);
    int bpp, ppw, k, ppb, sh;
    logic [31:0] v;
    bpp = p1 ? 4 : (2 << clrm);
    ppw = 32 / bpp;
    k   = x % ppw;
    if (bpp == 16) begin
      sh = 16 * k;
    end else begin
      ppb = 8 / bpp;
      sh  = 8 * (k / ppb) + 8 - bpp * (k % ppb + 1);
    end
    v = (w >> sh) & ((32'd1 << bpp) - 32'd1);
    return v[15:0];
  endfunction

  task automatic inv_pulse();
    bus.INVALIDATE = 1'b1;
    @(negedge clk);
    bus.INVALIDATE = 1'b0;
    m_vld = 1'b0;
  endtask

  // One complete read transaction with chosen memory/consumer delays
  task automatic do_read(input int x, input int y, input int clrm, input int ximm, input bit p1,
                         input int ack_dly, input int rv_dly, input int rdy_dly,
                         input bit inv_fill, output logic [15:0] got);
    int          addr;
    bit          hit;
    logic [31:0] w;
    logic [15:0] exp;
    addr = ref_addr(x, y, clrm, ximm, p1);
    hit  = CACHE_ON && m_vld && (m_tag == addr);
    if (!vram.exists(addr)) vram[addr] = $urandom;
    w    = hit ? m_word : vram[addr];
    exp  = ref_pix(w, x, clrm, p1);

    total++;
    if (bus.REQ_READY !== 1'b1) begin
      bad++; $display("FAIL req_ready_idle: got %b want 1", bus.REQ_READY);
    end
    bus.REQ_VALID = 1'b1;
    bus.REQ_X = x[10:0]; bus.REQ_Y = y[11:0]; bus.CLRM = clrm[1:0]; bus.XIMM = ximm[1:0]; bus.P1 = p1;
    @(negedge clk);
    // Scramble the request fields: the transaction must use the accepted values
    bus.REQ_VALID = 1'b0;
    bus.REQ_X = 11'($urandom); bus.REQ_Y = 12'($urandom);
    bus.CLRM = 2'($urandom); bus.XIMM = 2'($urandom); bus.P1 = 1'($urandom);
    total++;
    if (bus.REQ_READY !== 1'b0) begin
      bad++; $display("FAIL req_ready_busy: got %b want 0", bus.REQ_READY);
    end
    @(negedge clk);
    total++;
    if (bus.MEM_ADDR !== addr[18:0]) begin
      bad++; $display("FAIL mem_addr x=%0d y=%0d clrm=%0d ximm=%0d p1=%0d: got %h want %h",
                      x, y, clrm, ximm, p1, bus.MEM_ADDR, addr[18:0]);
    end
    total++;
    if (bus.MEM_REQ !== !hit || bus.RSP_VALID !== hit) begin
      bad++; $display("FAIL hit_miss_cycle2: got mem_req=%b rsp_valid=%b want hit=%b",
                      bus.MEM_REQ, bus.RSP_VALID, hit);
    end
    if (!hit) begin
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        total++;
        if (bus.MEM_REQ !== 1'b1 || bus.RSP_VALID !== 1'b0) begin
          bad++; $display("FAIL mem_req_hold: got mem_req=%b rsp_valid=%b want 1/0",
                          bus.MEM_REQ, bus.RSP_VALID);
        end
      end
      bus.MEM_ACK    = 1'b1;
      bus.MEM_RVALID = (rv_dly == 0);
      bus.MEM_RDATA  = (rv_dly == 0) ? vram[addr] : $urandom;
      bus.INVALIDATE = inv_fill && (rv_dly == 0);
      @(negedge clk);
      bus.MEM_ACK = 1'b0; bus.MEM_RVALID = 1'b0; bus.INVALIDATE = 1'b0;
      for (int i = 0; i < rv_dly; i++) begin
        total++;
        if (bus.MEM_REQ !== 1'b0 || bus.RSP_VALID !== 1'b0) begin
          bad++; $display("FAIL mwait: got mem_req=%b rsp_valid=%b want 0/0",
                          bus.MEM_REQ, bus.RSP_VALID);
        end
        if (i == rv_dly - 1) begin
          bus.MEM_RVALID = 1'b1; bus.MEM_RDATA = vram[addr]; bus.INVALIDATE = inv_fill;
        end
        @(negedge clk);
        bus.MEM_RVALID = 1'b0; bus.INVALIDATE = 1'b0;
      end
      m_tag  = addr;
      m_word = vram[addr];
      m_vld  = !inv_fill;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      total++;
      if (bus.RSP_VALID !== 1'b1 || bus.RSP_PIX !== exp) begin
        bad++; $display("FAIL rsp x=%0d clrm=%0d p1=%0d: got valid=%b pix=%h want 1 %h",
                        x, clrm, p1, bus.RSP_VALID, bus.RSP_PIX, exp);
      end
      if (i < rdy_dly) begin
        // stray read data while responding must be ignored
        bus.MEM_RVALID = 1'($urandom); bus.MEM_RDATA = $urandom;
        @(negedge clk);
        bus.MEM_RVALID = 1'b0;
      end
    end
    got = bus.RSP_PIX;
    bus.RSP_READY = 1'b1;
    @(negedge clk);
    bus.RSP_READY = 1'b0;
    total++;
    if (bus.RSP_VALID !== 1'b0 || bus.REQ_READY !== 1'b1) begin
      bad++; $display("FAIL rsp_done: got rsp_valid=%b req_ready=%b want 0/1",
                      bus.RSP_VALID, bus.REQ_READY);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (bus.REQ_READY !== 1'b0 || bus.MEM_REQ !== 1'b0 || bus.MEM_ADDR !== 19'd0 ||
        bus.RSP_VALID !== 1'b0 || bus.RSP_PIX !== 16'd0) begin
      bad++; $display("FAIL reset_vals: got rdy=%b mreq=%b addr=%h rv=%b pix=%h want 0 0 0 0 0",
                      bus.REQ_READY, bus.MEM_REQ, bus.MEM_ADDR, bus.RSP_VALID, bus.RSP_PIX);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.REQ_READY !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", bus.REQ_READY);
    end
    @(negedge clk);
  endtask

  task automatic test_plan_vectors();
    logic [15:0] g;
    vram[ref_addr(5, 3, CLRM_8BPP, XIMM_512, 1'b0)] = 32'h44332211;
    do_read(5, 3, CLRM_8BPP, XIMM_512, 1'b0, 1, 2, 1, 1'b0, g);
    total++;
    if (g !== 16'h0022) begin bad++; $display("FAIL plan_8bpp: got %h want 0022", g); end
    do_read(6, 3, CLRM_8BPP, XIMM_512, 1'b0, 0, 1, 0, 1'b0, g);
    total++;
    if (g !== 16'h0033) begin bad++; $display("FAIL plan_hit: got %h want 0033", g); end
    vram[ref_addr(13, 0, CLRM_2BPP, XIMM_256, 1'b0)] = 32'hE4000000;
    do_read(13, 0, CLRM_2BPP, XIMM_256, 1'b0, 0, 0, 0, 1'b0, g);
    total++;
    if (g !== 16'h0002) begin bad++; $display("FAIL plan_2bpp: got %h want 0002", g); end
    vram[ref_addr(11'h200, 1, CLRM_4BPP, XIMM_256, 1'b1)] = 32'h000000A5;
    do_read(11'h200, 1, CLRM_16BPP, XIMM_2048, 1'b1, 2, 0, 2, 1'b0, g);
    total++;
    if (g !== 16'h000A) begin bad++; $display("FAIL plan_p1: got %h want 000A", g); end
  endtask

  task automatic test_invalidate();
    logic [15:0] g;
    do_read(5, 3, CLRM_8BPP, XIMM_512, 1'b0, 0, 1, 0, 1'b0, g);
    do_read(6, 3, CLRM_8BPP, XIMM_512, 1'b0, 0, 1, 0, 1'b0, g);
    // blit write path updates the word and invalidates
    vram[ref_addr(6, 3, CLRM_8BPP, XIMM_512, 1'b0)] = 32'hA1B2C3D4;
    inv_pulse();
    do_read(6, 3, CLRM_8BPP, XIMM_512, 1'b0, 1, 1, 0, 1'b0, g);
    total++;
    if (g !== 16'h00B2) begin bad++; $display("FAIL inv_refetch: got %h want 00B2", g); end
    do_read(7, 3, CLRM_8BPP, XIMM_512, 1'b0, 0, 0, 0, 1'b1, g);
    do_read(4, 3, CLRM_8BPP, XIMM_512, 1'b0, 0, 2, 0, 1'b1, g);
    do_read(4, 3, CLRM_8BPP, XIMM_512, 1'b0, 0, 1, 1, 1'b0, g);
  endtask

  task automatic test_random();
    logic [15:0] g;
    int x, y, c, xm;
    for (int n = 0; n < 60; n++) begin
      x  = $urandom_range(0, 63);
      y  = $urandom_range(0, 3);
      c  = $urandom_range(0, 3);
      xm = $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        0: inv_pulse();
        1: begin
          vram[ref_addr(x, y, c, xm, 1'b0)] = $urandom;
          inv_pulse();
        end
        2: vram[ref_addr(x, y, c, xm, 1'b0)] = $urandom;  // stale cache must persist
        default: ;
      endcase
      do_read(x, y, c, xm, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 9) == 0), g);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] g;
    int c;
    c = $urandom_range(0, 3);
    for (int n = 0; n < 10; n++) begin
      do_read(n, 2, c, XIMM_1024, 1'b0, 0, 0, 0, 1'b0, g);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] g;
    for (int ph = 0; ph < 2; ph++) begin
      inv_pulse();
      bus.REQ_VALID = 1'b1; bus.REQ_X = 11'($urandom); bus.REQ_Y = 12'($urandom);
      bus.CLRM = 2'($urandom); bus.XIMM = 2'($urandom); bus.P1 = 1'b0;
      @(negedge clk);
      bus.REQ_VALID = 1'b0;
      @(negedge clk);
      total++;
      if (bus.MEM_REQ !== 1'b1) begin
        bad++; $display("FAIL abort_mreq_%0d: got %b want 1", ph, bus.MEM_REQ);
      end
      if (ph == 1) begin
        bus.MEM_ACK = 1'b1;
        @(negedge clk);
        bus.MEM_ACK = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bus.MEM_REQ !== 1'b0 || bus.RSP_VALID !== 1'b0 || bus.REQ_READY !== 1'b0 ||
          bus.MEM_ADDR !== 19'd0 || bus.RSP_PIX !== 16'd0) begin
        bad++; $display("FAIL abort_now_%0d: got mreq=%b rv=%b rdy=%b addr=%h pix=%h want all 0",
                        ph, bus.MEM_REQ, bus.RSP_VALID, bus.REQ_READY, bus.MEM_ADDR, bus.RSP_PIX);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_vld = 1'b0;
      bus.MEM_RVALID = 1'b1; bus.MEM_RDATA = $urandom;
      @(negedge clk);
      bus.MEM_RVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (bus.RSP_VALID !== 1'b0 || bus.MEM_REQ !== 1'b0 || bus.REQ_READY !== 1'b1) begin
          bad++; $display("FAIL late_rvalid_%0d: got rv=%b mreq=%b rdy=%b want 0 0 1",
                          ph, bus.RSP_VALID, bus.MEM_REQ, bus.REQ_READY);
        end
        @(negedge clk);
      end
    end
    do_read(9, 1, CLRM_16BPP, XIMM_256, 1'b0, 0, 1, 0, 1'b0, g);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.REQ_VALID = 1'b0; bus.REQ_X = '0; bus.REQ_Y = '0; bus.CLRM = '0; bus.XIMM = '0;
    bus.P1 = 1'b0; bus.MEM_ACK = 1'b0; bus.MEM_RVALID = 1'b0; bus.MEM_RDATA = '0;
    bus.RSP_READY = 1'b0; bus.INVALIDATE = 1'b0;
    test_reset();
    test_plan_vectors();
    test_invalidate();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
